// File: rtl/wb_arb_pkg.sv
// Shared types for the Ibex instruction/data Wishbone arbiter.
// Holds the FSM state encoding and the master index constants.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_e;

    localparam logic MASTER_INSTR = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;

endpackage

// File: rtl/wb_ibex_arbiter_if.sv
// Pipelined Wishbone bus bundle for one arbiter port.
// The master modport issues requests; the slave modport answers them.
interface wb_ibex_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat_w;
    logic              ack;
    logic              err;
    logic              stall;
    logic [31:0]       dat_r;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  ack, err, stall, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output ack, err, stall, dat_r
    );
endinterface

// File: rtl/wb_ibex_arbiter.sv
// Two-master round-robin arbiter sharing one pipelined Wishbone slave port.
// Ownership lasts while the owner holds cyc; an outstanding counter bounds requests in flight.
module wb_ibex_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W          = 28,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [3:0]        m0_sel,
    input  logic [31:0]       m0_dat_w,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m0_stall,
    output logic [31:0]       m0_dat_r,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [3:0]        m1_sel,
    input  logic [31:0]       m1_dat_w,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              m1_stall,
    output logic [31:0]       m1_dat_r,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [3:0]        s_sel,
    output logic [31:0]       s_dat_w,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic              s_stall,
    input  logic [31:0]       s_dat_r,

    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             last;
    logic [CNT_W-1:0] count;

    logic own_m0;
    logic own_m1;
    logic own_stb;
    logic full;
    logic cnt_nz;
    logic accept;
    logic resp;
    logic owner_drop;

    assign own_m0 = (state == OWN_M0);
    assign own_m1 = (state == OWN_M1);
    assign grant  = {own_m1, own_m0};
    assign full   = (count == CNT_W'(MAX_OUTSTANDING));
    assign cnt_nz = (count != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc)
                    state_nxt = (last == MASTER_INSTR) ? OWN_M1 : OWN_M0;
                else if (m1_cyc)
                    state_nxt = OWN_M1;
                else if (m0_cyc)
                    state_nxt = OWN_M0;
            end
            OWN_M0:  if (!m0_cyc) state_nxt = m1_cyc ? OWN_M1 : IDLE;
            OWN_M1:  if (!m1_cyc) state_nxt = m0_cyc ? OWN_M0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared-port request mux: everything follows the owner, all zero when idle.
    always_comb begin
        s_cyc   = 1'b0;
        own_stb = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_w = '0;
        if (own_m0) begin
            s_cyc   = m0_cyc;
            own_stb = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_sel   = m0_sel;
            s_dat_w = m0_dat_w;
        end else if (own_m1) begin
            s_cyc   = m1_cyc;
            own_stb = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_sel   = m1_sel;
            s_dat_w = m1_dat_w;
        end
    end

    assign s_stb      = own_stb & ~full;
    assign accept     = s_stb & ~s_stall;
    assign resp       = (s_ack | s_err) & cnt_nz;
    assign owner_drop = (own_m0 & ~m0_cyc) | (own_m1 & ~m1_cyc);

    assign m0_ack   = own_m0 & s_ack & cnt_nz;
    assign m0_err   = own_m0 & s_err & cnt_nz;
    assign m0_stall = own_m0 ? (s_stall | full) : 1'b1;
    assign m0_dat_r = own_m0 ? s_dat_r : '0;
    assign m1_ack   = own_m1 & s_ack & cnt_nz;
    assign m1_err   = own_m1 & s_err & cnt_nz;
    assign m1_stall = own_m1 ? (s_stall | full) : 1'b1;
    assign m1_dat_r = own_m1 ? s_dat_r : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= MASTER_INSTR;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN_M0)
                last <= MASTER_INSTR;
            else if (state_nxt == OWN_M1)
                last <= MASTER_DATA;
        end
    end

    // Dropping cyc abandons everything in flight, so late responses fall on count == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (owner_drop) begin
            count <= '0;
        end else if (accept && !resp) begin
            count <= count + CNT_W'(1);
        end else if (resp && !accept) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_ibex_arbiter.sv
// Directed bench for wb_ibex_arbiter: single master bursts, round-robin tie,
// outstanding limit, error responses, abandoned transfers and asynchronous reset.
module tb_wb_ibex_arbiter;

    localparam int ADDR_W = 28;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] grant;

    wb_ibex_arbiter_if #(.ADDR_W(ADDR_W)) m0_bus ();
    wb_ibex_arbiter_if #(.ADDR_W(ADDR_W)) m1_bus ();
    wb_ibex_arbiter_if #(.ADDR_W(ADDR_W)) s_bus ();

    int tests = 0;
    int fails = 0;
    int stb_pulses;
    int ack_pulses;
    int err_pulses;
    logic m0_stall_all;

    always #5 clk = ~clk;

    wb_ibex_arbiter #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_cyc   (m0_bus.cyc),
        .m0_stb   (m0_bus.stb),
        .m0_we    (m0_bus.we),
        .m0_adr   (m0_bus.adr),
        .m0_sel   (m0_bus.sel),
        .m0_dat_w (m0_bus.dat_w),
        .m0_ack   (m0_bus.ack),
        .m0_err   (m0_bus.err),
        .m0_stall (m0_bus.stall),
        .m0_dat_r (m0_bus.dat_r),
        .m1_cyc   (m1_bus.cyc),
        .m1_stb   (m1_bus.stb),
        .m1_we    (m1_bus.we),
        .m1_adr   (m1_bus.adr),
        .m1_sel   (m1_bus.sel),
        .m1_dat_w (m1_bus.dat_w),
        .m1_ack   (m1_bus.ack),
        .m1_err   (m1_bus.err),
        .m1_stall (m1_bus.stall),
        .m1_dat_r (m1_bus.dat_r),
        .s_cyc    (s_bus.cyc),
        .s_stb    (s_bus.stb),
        .s_we     (s_bus.we),
        .s_adr    (s_bus.adr),
        .s_sel    (s_bus.sel),
        .s_dat_w  (s_bus.dat_w),
        .s_ack    (s_bus.ack),
        .s_err    (s_bus.err),
        .s_stall  (s_bus.stall),
        .s_dat_r  (s_bus.dat_r),
        .grant    (grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = '0;
        m0_bus.sel = 4'hF; m0_bus.dat_w = '0;
        m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = 0; m1_bus.adr = '0;
        m1_bus.sel = 4'hF; m1_bus.dat_w = 32'h1234_5678;
        s_bus.ack = 1; s_bus.err = 0; s_bus.stall = 0; s_bus.dat_r = 32'h5555_AAAA;
        rst_n = 0;

        // reset state with requests and responses already asserted
        #2;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_s_cyc", 64'(s_bus.cyc), 64'd0);
        check("rst_s_stb", 64'(s_bus.stb), 64'd0);
        check("rst_s_dat_w", 64'(s_bus.dat_w), 64'd0);
        check("rst_m0_stall", 64'(m0_bus.stall), 64'd1);
        check("rst_m1_stall", 64'(m1_bus.stall), 64'd1);
        check("rst_m1_ack", 64'(m1_bus.ack), 64'd0);
        check("rst_m1_dat_r", 64'(m1_bus.dat_r), 64'd0);
        tick();
        m1_bus.cyc = 0; m1_bus.stb = 0; s_bus.ack = 0;
        rst_n = 1;
        tick();

        // m1 alone: three back-to-back writes, slave acks two cycles after acceptance
        m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = 1; m1_bus.adr = 28'h100;
        #1;
        check("t1_grant_idle", 64'(grant), 64'd0);
        check("t1_m1_stall_idle", 64'(m1_bus.stall), 64'd1);
        tick();
        check("t1_grant_m1", 64'(grant), 64'b10);
        stb_pulses = 0; ack_pulses = 0; m0_stall_all = 1;
        for (int i = 0; i < 6; i++) begin
            m1_bus.stb = (i < 3);
            m1_bus.adr = 28'h100 + 28'(i);
            s_bus.ack = (i >= 2 && i <= 4);
            #1;
            if (s_bus.stb && !s_bus.stall) stb_pulses++;
            if (m1_bus.ack) ack_pulses++;
            if (m0_bus.stall !== 1'b1) m0_stall_all = 0;
            if (i == 1) check("t1_s_adr", 64'(s_bus.adr), 64'h101);
            if (i == 1) check("t1_s_we", 64'(s_bus.we), 64'd1);
            tick();
        end
        check("t1_stb_pulses", 64'(stb_pulses), 64'd3);
        check("t1_ack_pulses", 64'(ack_pulses), 64'd3);
        check("t1_m0_stall_all", 64'(m0_stall_all), 64'd1);
        m1_bus.cyc = 0; m1_bus.stb = 0; s_bus.ack = 0;
        tick();
        check("t1_grant_release", 64'(grant), 64'd0);

        // fresh reset, then a tie: m1 first, m0 takes over with no idle cycle
        rst_n = 0;
        #1;
        rst_n = 1;
        m0_bus.cyc = 1; m1_bus.cyc = 1;
        #1;
        check("t2_grant_idle", 64'(grant), 64'd0);
        tick();
        check("t2_grant_m1", 64'(grant), 64'b10);
        tick();
        check("t2_grant_hold", 64'(grant), 64'b10);
        m1_bus.cyc = 0;
        #1;
        check("t2_grant_drop_cycle", 64'(grant), 64'b10);
        tick();
        check("t2_grant_handover", 64'(grant), 64'b01);
        m0_bus.cyc = 0;
        tick();
        check("t2_grant_none", 64'(grant), 64'd0);

        // outstanding limit: slave never acks, six strobes from m0
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1;
        tick();
        check("t3_grant_m0", 64'(grant), 64'b01);
        stb_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            m0_bus.adr = 28'h300 + 28'(i);
            #1;
            if (s_bus.stb && !s_bus.stall) stb_pulses++;
            if (i == 4) check("t3_stall_5th", 64'(m0_bus.stall), 64'd1);
            tick();
        end
        check("t3_accepted", 64'(stb_pulses), 64'd4);
        s_bus.ack = 1;
        #1;
        check("t3_ack_fwd", 64'(m0_bus.ack), 64'd1);
        check("t3_s_stb_full", 64'(s_bus.stb), 64'd0);
        tick();
        s_bus.ack = 0;
        #1;
        check("t3_5th_stall", 64'(m0_bus.stall), 64'd0);
        check("t3_5th_stb", 64'(s_bus.stb), 64'd1);
        tick();
        check("t3_full_again", 64'(m0_bus.stall), 64'd1);
        m0_bus.stb = 0; m0_bus.cyc = 0;
        tick();

        // three reads from m0, the second answered with an error
        m0_bus.cyc = 1; m0_bus.we = 0;
        tick();
        check("t4_grant_m0", 64'(grant), 64'b01);
        m0_bus.stb = 1; m0_bus.adr = 28'h200;
        tick();
        m0_bus.adr = 28'h201;
        tick();
        ack_pulses = 0; err_pulses = 0;
        m0_bus.adr = 28'h202; s_bus.ack = 1; s_bus.dat_r = 32'hDEAD_BEEF;
        #1;
        check("t4_m0_dat_r", 64'(m0_bus.dat_r), 64'hDEAD_BEEF);
        check("t4_m1_dat_r", 64'(m1_bus.dat_r), 64'd0);
        check("t4_m1_ack", 64'(m1_bus.ack), 64'd0);
        ack_pulses += int'(m0_bus.ack); err_pulses += int'(m0_bus.err);
        tick();
        m0_bus.stb = 0; s_bus.ack = 0; s_bus.err = 1;
        #1;
        check("t4_m1_err", 64'(m1_bus.err), 64'd0);
        ack_pulses += int'(m0_bus.ack); err_pulses += int'(m0_bus.err);
        tick();
        s_bus.err = 0; s_bus.ack = 1; s_bus.dat_r = 32'h0000_CAFE;
        #1;
        ack_pulses += int'(m0_bus.ack); err_pulses += int'(m0_bus.err);
        tick();
        #1;
        check("t4_count_zero", 64'(m0_bus.ack), 64'd0);
        ack_pulses += int'(m0_bus.ack); err_pulses += int'(m0_bus.err);
        check("t4_ack_pulses", 64'(ack_pulses), 64'd2);
        check("t4_err_pulses", 64'(err_pulses), 64'd1);
        s_bus.ack = 0; m0_bus.cyc = 0;
        tick();

        // m1 abandons two outstanding writes; late ack must vanish
        m1_bus.cyc = 1; m1_bus.we = 1; s_bus.stall = 1;
        tick();
        check("t5_grant_m1", 64'(grant), 64'b10);
        m1_bus.stb = 1;
        #1;
        check("t5_slave_stall", 64'(m1_bus.stall), 64'd1);
        tick();
        s_bus.stall = 0;
        tick();
        tick();
        m1_bus.cyc = 0; m1_bus.stb = 0;
        #1;
        check("t5_s_cyc_drop", 64'(s_bus.cyc), 64'd0);
        check("t5_s_stb_drop", 64'(s_bus.stb), 64'd0);
        tick();
        check("t5_grant_none", 64'(grant), 64'd0);
        s_bus.ack = 1;
        #1;
        check("t5_late_m1_ack", 64'(m1_bus.ack), 64'd0);
        check("t5_late_m0_ack", 64'(m0_bus.ack), 64'd0);
        m0_bus.cyc = 1;
        tick();
        check("t5_grant_m0", 64'(grant), 64'b01);
        #1;
        check("t5_count_cleared", 64'(m0_bus.ack), 64'd0);
        s_bus.ack = 0; m0_bus.cyc = 0;
        tick();

        // asynchronous reset in the middle of an m1 burst
        m1_bus.cyc = 1; m1_bus.stb = 1;
        tick();
        check("t6_grant_m1", 64'(grant), 64'b10);
        tick();
        #2;
        rst_n = 0; s_bus.ack = 1; m0_bus.cyc = 1;
        #1;
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_s_cyc", 64'(s_bus.cyc), 64'd0);
        check("t6_rst_s_stb", 64'(s_bus.stb), 64'd0);
        check("t6_rst_m0_stall", 64'(m0_bus.stall), 64'd1);
        check("t6_rst_m1_stall", 64'(m1_bus.stall), 64'd1);
        check("t6_rst_m1_ack", 64'(m1_bus.ack), 64'd0);
        tick();
        #2;
        rst_n = 1;
        #1;
        check("t6_post_rst_grant", 64'(grant), 64'd0);
        tick();
        check("t6_m1_priority", 64'(grant), 64'b10);
        #1;
        check("t6_no_stale_ack", 64'(m1_bus.ack), 64'd0);
        m1_bus.cyc = 0; m1_bus.stb = 0; s_bus.ack = 0;
        tick();
        check("t6_handover_m0", 64'(grant), 64'b01);
        m0_bus.cyc = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_ibex_arbiter.md
WB_IBEX_ARBITER -- requirements
Module: wb_ibex_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning Wishbone word-address width.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum accepted-but-unacknowledged requests on the shared port (1..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset (asynchronous, active-low).
REQ-005 The block SHALL have per-master input ports m0_* (instruction master) and m1_* (data master): cyc, stb, we (1 each), adr (ADDR_W), sel (4) and dat_w (32), meaning Wishbone pipelined master requests.
REQ-006 The block SHALL have per-master output ports m0_*/m1_*: ack, err, stall (1 each) and dat_r (32), meaning per-master responses.
REQ-007 The block SHALL have shared-slave output ports s_cyc, s_stb, s_we (1 each), s_adr (ADDR_W), s_sel (4) and s_dat_w (32).
REQ-008 The block SHALL have shared-slave input ports s_ack, s_err, s_stall (1 each) and s_dat_r (32).
REQ-009 The block SHALL have output port grant, 2, meaning a one-hot current owner (00 = none).

Function
REQ-010 The arbiter SHALL implement an FSM with states IDLE, OWN_M0 and OWN_M1.
REQ-011 In IDLE, the FSM SHALL go to OWN_M0 or OWN_M1 on the next clock edge after the corresponding cyc is sampled high.
REQ-012 In IDLE with both cyc high, the FSM SHALL grant the master not granted last (round-robin); the first request after reset SHALL go to m1.
REQ-013 In OWN_x, the FSM SHALL hold the grant while mx_cyc is high; no pre-emption is allowed.
REQ-014 In OWN_x with mx_cyc low, the FSM SHALL move on the next edge to the other OWN state if the other master's cyc is high, else to IDLE; there SHALL be no idle bubble on handover.
REQ-015 In OWN_x, s_cyc/s_we/s_adr/s_sel/s_dat_w SHALL combinationally follow master x.
REQ-016 In OWN_x, s_stb SHALL equal mx_stb AND NOT full.
REQ-017 In IDLE, all s_* outputs SHALL be 0.
REQ-018 The owner SHALL receive mx_ack = s_ack and mx_err = s_err, gated by count != 0; mx_dat_r = s_dat_r; mx_stall = s_stall OR full.
REQ-019 A non-owner SHALL see stall = 1, ack = 0, err = 0 and dat_r = 0.
REQ-020 An outstanding counter (width clog2(MAX_OUTSTANDING+1)) SHALL increment on s_stb AND NOT s_stall and decrement on gated (s_ack OR s_err); simultaneous increment and decrement SHALL leave it unchanged.
REQ-021 full SHALL be asserted when count == MAX_OUTSTANDING.
REQ-022 s_ack/s_err arriving with count == 0 SHALL be dropped, with no underflow.
REQ-023 If the owner drops cyc with count != 0, the counter SHALL clear on that edge and s_cyc SHALL go low in the same cycle (combinational); late slave responses SHALL be dropped per REQ-022.
REQ-024 Arbitration latency SHALL be one cycle from cyc to grant; in steady state, one request per cycle SHALL be accepted unless stalled.

Reset
REQ-025 On rst_n low, the arbiter SHALL asynchronously go to state IDLE with count = 0 and last-granted = m0, so m1 wins the first tie.
REQ-026 During reset, grant SHALL be 00, all s_* outputs 0, both mx_stall 1 and all mx_ack/err 0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer; no ack SHALL be forwarded after reset deasserts.

Structure
REQ-028 The FSM state enum and the MASTER_INSTR/MASTER_DATA index constants SHALL reside in the shared package wb_arb_pkg.
REQ-029 The design SHALL be a single module with no sub-modules; the mux and counter SHALL be inline.

Verification
REQ-030 Verification SHALL cover: m1 only, 3 back-to-back writes, slave ack latency 2 -> grant=10 the cycle after cyc, 3 s_stb pulses, 3 m1_ack pulses, m0_stall=1 throughout.
REQ-031 Verification SHALL cover: m0 and m1 raise cyc in the same cycle after reset -> m1 is granted first; m0 is granted the cycle m1_cyc drops, with no IDLE cycle.
REQ-032 Verification SHALL cover: MAX_OUTSTANDING=4, slave never acks, m0 issues 6 stb -> exactly 4 accepted, m0_stall=1 from the 5th; one ack -> 5th accepted.
REQ-033 Verification SHALL cover: s_err on the 2nd of 3 reads -> m0_err pulses once, the count still reaches 0, and m0_ack pulses twice.
REQ-034 Verification SHALL cover: owner drops cyc with 2 outstanding -> s_cyc is low the same cycle, a later s_ack is not forwarded to either master, and count = 0.
REQ-035 Verification SHALL cover: rst_n pulsed low mid-burst, asynchronously off-edge -> outputs reach their reset values before the next clk edge, and arbitration restarts with m1 priority.
